// File: rtl/i2c_reg_sequencer.sv
// Purpose: turns one single-register I2C read/write request into TXR/CR writes and SR polls on the I2C controller.
// Latency: each Wishbone access is held until ack and followed by one idle cycle; response pulses one cycle after the final evaluation.
// Backpressure: req_ready_o is high only in IDLE; requests are held off while busy, never dropped or queued.
module i2c_reg_sequencer #(
    parameter int TIMEOUT_POLLS = 4096
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    output logic       wbm_we_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    input  logic       wbm_ack_i
);
    localparam int              CW       = $clog2(TIMEOUT_POLLS + 1);
    localparam logic [CW-1:0]   POLL_MAX = CW'(TIMEOUT_POLLS);

    localparam logic [2:0] ADR_TXR = 3'd3;   // TXR write / RXR read
    localparam logic [2:0] ADR_CR  = 3'd4;   // CR write / SR read

    // Every CR value carries IACK (bit0) so a stale interrupt flag is cleared.
    localparam logic [7:0] CRV_STA_WR   = 8'h91;
    localparam logic [7:0] CRV_WR       = 8'h11;
    localparam logic [7:0] CRV_STO_WR   = 8'h51;
    localparam logic [7:0] CRV_RD_STO   = 8'h69;
    localparam logic [7:0] CRV_STO_IACK = 8'h41;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_AL      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE, TXR_WR, CR_WR, POLL, EVAL, RXR_RD, ABORT, RESP
    } state_t;

    state_t        state, state_nxt;
    logic          rnw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic [7:0]    wdata_q;
    logic [1:0]    uop;          // index of the current command within the sequence
    logic          uop_adv;
    logic          aborting;     // set while the STOP-after-NACK command is in flight
    logic [CW-1:0] poll_cnt, poll_cnt_nxt;
    logic          al_q, rxack_q;
    logic [1:0]    err_nxt;
    logic          acc_done;
    logic          acc_req, acc_we;
    logic [2:0]    acc_adr;
    logic [7:0]    acc_dat;
    logic [7:0]    txr_byte, cr_byte;
    logic          last_uop, rd_cmd;

    assign acc_done     = wbm_stb_o & wbm_ack_i;
    assign req_ready_o  = (state == IDLE);
    assign rsp_valid_o  = (state == RESP);
    assign last_uop     = rnw_q ? (uop == 2'd3) : (uop == 2'd2);
    assign rd_cmd       = rnw_q && (uop == 2'd3);
    assign poll_cnt_nxt = (poll_cnt == POLL_MAX) ? poll_cnt : poll_cnt + 1'b1;

    // Byte and CR value selected by the micro-op index, and the access each state issues.
    always_comb begin
        txr_byte = 8'h00;
        cr_byte  = CRV_STA_WR;
        acc_req  = 1'b0;
        acc_we   = 1'b0;
        acc_adr  = 3'd0;
        acc_dat  = 8'h00;
        case (uop)
            2'd0: begin txr_byte = {dev_q, 1'b0}; cr_byte = CRV_STA_WR; end
            2'd1: begin txr_byte = reg_q;         cr_byte = CRV_WR;     end
            2'd2: begin
                txr_byte = rnw_q ? {dev_q, 1'b1} : wdata_q;
                cr_byte  = rnw_q ? CRV_STA_WR : CRV_STO_WR;
            end
            default: begin txr_byte = 8'h00; cr_byte = CRV_RD_STO; end
        endcase
        case (state)
            TXR_WR: begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_TXR; acc_dat = txr_byte;     end
            CR_WR:  begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CR;  acc_dat = cr_byte;      end
            ABORT:  begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CR;  acc_dat = CRV_STO_IACK; end
            POLL:   begin acc_req = 1'b1; acc_adr = ADR_CR;  end
            RXR_RD: begin acc_req = 1'b1; acc_adr = ADR_TXR; end
            default: ;
        endcase
    end

    // Next-state and response-code decisions.
    always_comb begin
        state_nxt = state;
        err_nxt   = ERR_OK;
        uop_adv   = 1'b0;
        case (state)
            IDLE:   if (req_valid_i) state_nxt = TXR_WR;
            TXR_WR: if (acc_done) state_nxt = CR_WR;
            CR_WR:  if (acc_done) state_nxt = POLL;
            ABORT:  if (acc_done) state_nxt = POLL;
            POLL: begin
                if (acc_done) begin
                    if (wbm_dat_i[0] || wbm_dat_i[5]) begin
                        state_nxt = EVAL;
                    end else if (poll_cnt_nxt == POLL_MAX) begin
                        // No STOP on timeout: bus recovery is left to the system.
                        state_nxt = RESP;
                        err_nxt   = ERR_TIMEOUT;
                    end
                end
            end
            EVAL: begin
                if (al_q) begin
                    state_nxt = RESP;
                    err_nxt   = ERR_AL;
                end else if (aborting) begin
                    state_nxt = RESP;
                    err_nxt   = ERR_NACK;
                end else if (rxack_q && !rd_cmd) begin
                    state_nxt = ABORT;
                end else if (last_uop) begin
                    state_nxt = rnw_q ? RXR_RD : RESP;
                end else begin
                    uop_adv   = 1'b1;
                    // The final read command carries no TXR byte.
                    state_nxt = (rnw_q && uop == 2'd2) ? CR_WR : TXR_WR;
                end
            end
            RXR_RD: if (acc_done) state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Wishbone master: launch from an idle bus, hold until ack, drop on the ack edge.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 3'd0;
            wbm_dat_o <= 8'h00;
        end else if (acc_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 3'd0;
            wbm_dat_o <= 8'h00;
        end else if (acc_req && !wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= acc_we;
            wbm_adr_o <= acc_adr;
            wbm_dat_o <= acc_dat;
        end
    end

    // Request capture, micro-op index, poll counter, status flags and response registers.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            rnw_q       <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            uop         <= 2'd0;
            aborting    <= 1'b0;
            poll_cnt    <= '0;
            al_q        <= 1'b0;
            rxack_q     <= 1'b0;
            rsp_rdata_o <= 8'h00;
            rsp_err_o   <= ERR_OK;
        end else begin
            if (state == IDLE && req_valid_i) begin
                rnw_q       <= req_rnw_i;
                dev_q       <= req_dev_i;
                reg_q       <= req_reg_i;
                wdata_q     <= req_wdata_i;
                uop         <= 2'd0;
                aborting    <= 1'b0;
                poll_cnt    <= '0;
                rsp_rdata_o <= 8'h00;
                rsp_err_o   <= ERR_OK;
            end
            if (uop_adv) uop <= uop + 1'b1;
            if (state == EVAL && state_nxt == ABORT) aborting <= 1'b1;
            if ((state == CR_WR || state == ABORT) && acc_done) poll_cnt <= '0;
            if (state == POLL && acc_done) begin
                poll_cnt <= poll_cnt_nxt;
                al_q     <= wbm_dat_i[5];
                rxack_q  <= wbm_dat_i[7];
            end
            if (state == RXR_RD && acc_done) rsp_rdata_o <= wbm_dat_i;
            if (state != RESP && state_nxt == RESP) rsp_err_o <= err_nxt;
        end
    end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: scripted I2C-controller slave plus a transaction-level expectation model.
// Each slave acceptance is compared with the model's next expected access; each response with the model's result.
// Slave inserts configurable wait states so held-until-ack behaviour is exercised.
module tb_i2c_reg_sequencer;
    localparam int TO       = 8;
    localparam int IF_AFTER = 2;   // SR reads per command before the scripted slave raises IF

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rnw = 1'b0;
    logic [6:0] req_dev = 7'd0;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       wbm_cyc, wbm_stb, wbm_we;
    logic [2:0] wbm_adr;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i = 8'h00;
    logic       wbm_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];         // {we, adr, dat}; dat is 0 for reads
    logic [1:0]  exp_err = 2'b00;
    logic [7:0]  exp_rdata = 8'h00;

    int          wait_states = 0;
    int          nack_cmd = -1;
    int          al_cmd = -1;
    bit          never_if = 1'b0;
    logic [7:0]  rxr_val = 8'h00;
    int          cmd_idx = -1;
    int          polls_in_cmd = 0;
    int          sr_reads = 0;
    int          wait_cnt = 0;
    logic [11:0] snap = 12'h000;
    logic [7:0]  cr_log[$];
    logic [7:0]  txr_log[$];
    int          rsp_count = 0;

    initial forever #5 clk = ~clk;

    i2c_reg_sequencer #(.TIMEOUT_POLLS(TO)) dut (
        .wb_clk_i    (clk),
        .arst_i      (arst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rnw_i   (req_rnw),
        .req_dev_i   (req_dev),
        .req_reg_i   (req_reg),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected bus accesses and result, derived from the command list and the slave script.
    task automatic build_expected(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                                  input logic [7:0] wd, input logic [7:0] rd_val);
        logic [8:0] txr[4];   // bit8 marks a command that loads TXR first
        logic [7:0] cr[4];
        int n;
        exp_q.delete();
        exp_err   = 2'b00;
        exp_rdata = 8'h00;
        txr[0] = {1'b1, dev, 1'b0}; cr[0] = 8'h91;
        txr[1] = {1'b1, rg};        cr[1] = 8'h11;
        if (rnw) begin
            txr[2] = {1'b1, dev, 1'b1}; cr[2] = 8'h91;
            txr[3] = 9'h000;            cr[3] = 8'h69;
            n = 4;
        end else begin
            txr[2] = {1'b1, wd}; cr[2] = 8'h51;
            txr[3] = 9'h000;     cr[3] = 8'h00;
            n = 3;
        end
        for (int i = 0; i < n; i++) begin
            if (txr[i][8]) exp_q.push_back({1'b1, 3'd3, txr[i][7:0]});
            exp_q.push_back({1'b1, 3'd4, cr[i]});
            if (never_if) begin
                repeat (TO) exp_q.push_back({1'b0, 3'd4, 8'h00});
                exp_err = 2'b11;
                return;
            end
            repeat (IF_AFTER) exp_q.push_back({1'b0, 3'd4, 8'h00});
            if (i == al_cmd) begin
                exp_err = 2'b10;
                return;
            end
            if (i == nack_cmd && cr[i] != 8'h69) begin
                exp_q.push_back({1'b1, 3'd4, 8'h41});
                repeat (IF_AFTER) exp_q.push_back({1'b0, 3'd4, 8'h00});
                exp_err = 2'b01;
                return;
            end
        end
        if (rnw) begin
            exp_q.push_back({1'b0, 3'd3, 8'h00});
            exp_rdata = rd_val;
        end
    endtask

    // Slave acceptance: compare against the model, then apply the controller's side effects.
    task automatic accept(input logic [11:0] cur);
        logic [11:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL bus_access: got 0x%03h expected no access", cur);
        end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
                failures++;
                $display("FAIL bus_access: got 0x%03h expected 0x%03h", cur, e);
            end
        end
        if (cur[11]) begin
            if (cur[10:8] == 3'd3) txr_log.push_back(cur[7:0]);
            else if (cur[10:8] == 3'd4) begin
                cr_log.push_back(cur[7:0]);
                cmd_idx++;
                polls_in_cmd = 0;
            end
        end else if (cur[10:8] == 3'd4) begin
            polls_in_cmd++;
            sr_reads++;
            if (never_if || polls_in_cmd < IF_AFTER) wbm_dat_i = 8'h02;
            else wbm_dat_i = 8'h01 | ((cmd_idx == nack_cmd) ? 8'h80 : 8'h00)
                                   | ((cmd_idx == al_cmd) ? 8'h20 : 8'h00);
        end else begin
            wbm_dat_i = rxr_val;
        end
    endtask

    // Compare process: responses, busy/ready, bus protocol and every accepted access.
    initial begin : compare_proc
        logic [11:0] cur;
        forever begin
            @(negedge clk);
            if (arst) begin
                wbm_ack  = 1'b0;
                wait_cnt = 0;
            end else begin
                if (rsp_valid) begin
                    check("rsp_err", 32'(rsp_err), 32'(exp_err));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                    rsp_count++;
                end
                if (wbm_cyc) check("ready_low_while_busy", 32'(req_ready), 0);
                cur = {wbm_we, wbm_adr, wbm_we ? wbm_dat_o : 8'h00};
                if (wbm_ack) begin
                    check("strobe_dropped_after_ack", 32'({wbm_cyc, wbm_stb}), 0);
                    wbm_ack = 1'b0;
                end else if (wbm_stb) begin
                    if (wait_cnt == 0) snap = cur;
                    else check("held_until_ack", 32'(cur), 32'(snap));
                    if (wait_cnt < wait_states) wait_cnt++;
                    else begin
                        wait_cnt = 0;
                        accept(cur);
                        wbm_ack = 1'b1;
                    end
                end
            end
        end
    end

    task automatic setup(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                         input logic [7:0] rd_val, input int ws, input int nack_c, input int al_c,
                         input bit never);
        wait_states = ws;
        nack_cmd    = nack_c;
        al_cmd      = al_c;
        never_if    = never;
        rxr_val     = rd_val;
        cmd_idx     = -1;
        polls_in_cmd = 0;
        sr_reads    = 0;
        cr_log.delete();
        txr_log.delete();
        build_expected(rnw, dev, rg, wd, rd_val);
    endtask

    task automatic present(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        @(negedge clk); #1;
        check("ready_before_req", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_test(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                            input logic [7:0] rd_val, input int ws, input int nack_c, input int al_c,
                            input bit never);
        int start;
        int n;
        setup(rnw, dev, rg, wd, rd_val, ws, nack_c, al_c, never);
        start = rsp_count;
        present(rnw, dev, rg, wd);
        n = 0;
        while (rsp_count == start && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (rsp_count == start) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got no response in 400 cycles, expected one");
        end else begin
            check("accesses_remaining", 32'(exp_q.size()), 0);
            @(negedge clk); #1;
            check("ready_after_rsp", 32'(req_ready), 1);
            check("rsp_valid_one_cycle", 32'(rsp_valid), 0);
            check("rsp_pulse_count", 32'(rsp_count - start), 1);
        end
    endtask

    initial begin : driver
        int start;
        int n;
        #12;
        check("reset_ready", 32'(req_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_cyc_stb_we", 32'({wbm_cyc, wbm_stb, wbm_we}), 0);
        check("reset_adr", 32'(wbm_adr), 0);
        check("reset_dat", 32'(wbm_dat_o), 0);
        check("reset_rsp_data", 32'({rsp_err, rsp_rdata}), 0);
        repeat (2) @(negedge clk);
        #1 arst = 1'b0;

        // Write dev 0x50 reg 0x12 data 0xA5, all ACKed.
        run_test(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, -1, -1, 1'b0);
        check("wr_cr_count", 32'(cr_log.size()), 3);
        check("wr_cr0", 32'(cr_log[0]), 32'h91);
        check("wr_cr1", 32'(cr_log[1]), 32'h11);
        check("wr_cr2", 32'(cr_log[2]), 32'h51);
        check("wr_txr0", 32'(txr_log[0]), 32'hA0);
        check("wr_txr1", 32'(txr_log[1]), 32'h12);
        check("wr_txr2", 32'(txr_log[2]), 32'hA5);
        check("wr_rsp", 32'({rsp_err, rsp_rdata}), 0);

        // Read dev 0x50 reg 0x07, slave returns 0x3C, with wait states.
        run_test(1'b1, 7'h50, 8'h07, 8'h00, 8'h3C, 1, -1, -1, 1'b0);
        check("rd_cr_count", 32'(cr_log.size()), 4);
        check("rd_cr2", 32'(cr_log[2]), 32'h91);
        check("rd_cr3", 32'(cr_log[3]), 32'h69);
        check("rd_txr_rstart", 32'(txr_log[2]), 32'hA1);
        check("rd_data", 32'(rsp_rdata), 32'h3C);

        // Device-address NACK.
        run_test(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 0, -1, 1'b0);
        check("nack_cr_abort", 32'(cr_log[1]), 32'h41);
        check("nack_txr_count", 32'(txr_log.size()), 1);
        check("nack_err", 32'(rsp_err), 1);

        // Arbitration lost during the second command.
        run_test(1'b0, 7'h3B, 8'h80, 8'h5A, 8'h00, 0, -1, 1, 1'b0);
        check("al_cr_count", 32'(cr_log.size()), 2);
        check("al_no_stop", 32'(cr_log[1]), 32'h11);
        check("al_err", 32'(rsp_err), 2);

        // Controller never raises IF.
        run_test(1'b0, 7'h10, 8'h01, 8'h02, 8'h00, 0, -1, -1, 1'b1);
        check("to_sr_reads", 32'(sr_reads), TO);
        check("to_cr_count", 32'(cr_log.size()), 1);
        check("to_err", 32'(rsp_err), 3);

        // Reset pulsed while a strobe is high mid-read.
        setup(1'b1, 7'h50, 8'h07, 8'h00, 8'h3C, 1, -1, -1, 1'b0);
        start = rsp_count;
        present(1'b1, 7'h50, 8'h07, 8'h00);
        n = 0;
        while (!(wbm_stb && !wbm_ack && sr_reads >= 1) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_found_strobe", 32'(wbm_stb), 1);
        arst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_cyc_stb", 32'({wbm_cyc, wbm_stb}), 0);
        repeat (2) @(negedge clk);
        #1 arst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_no_rsp", 32'(rsp_count - start), 0);
        check("rst_ready", 32'(req_ready), 1);
        run_test(1'b0, 7'h2A, 8'hFF, 8'h00, 8'h00, 0, -1, -1, 1'b0);
        check("post_rst_err", 32'(rsp_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
